// File: rtl/sync_fifo_param_pkg.sv
// rtl/sync_fifo_param_pkg.sv - shared types for the parametrised synchronous FIFO
// Purpose: read-mode enum shared by the FIFO top and its users.
// Ports: none (package).
package sync_fifo_param_pkg;

  // FIFO_STD: data_out is registered one cycle after an accepted read.
  // FIFO_FWFT: the head word is shown on data_out while the FIFO is not empty.
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bundle of the synchronous FIFO
// Purpose: groups the write, read and status signals of one FIFO.
// Ports (signals): data_in, wr_en, rd_en towards the FIFO; data_out, data_valid,
//   wr_ack, overflow, underflow, full, empty, almost_full, almost_empty, count back.
//   master = producer/consumer side, slave = FIFO side.
interface sync_fifo_param_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) ();
  logic [DATA_W-1:0] data_in;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              wr_ack;
  logic              overflow;
  logic              underflow;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, data_valid, wr_ack, overflow, underflow,
           full, empty, almost_full, almost_empty, count
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, data_valid, wr_ack, overflow, underflow,
           full, empty, almost_full, almost_empty, count
  );
endinterface

// File: rtl/sync_fifo_param_mem.sv
// rtl/sync_fifo_param_mem.sv - FIFO storage array, one write port, one async read port
// Purpose: DATA_W x DEPTH word storage without reset.
// Ports: clk (clock), i_we (write enable), i_waddr/i_wdata (write address/data),
//   i_raddr (read address), o_rdata (combinational read data).
module sync_fifo_param_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with status and FWFT option
// Purpose: pointer/count control, flag decode, handshake pulses and read output stage.
// Ports: clk (rising-edge clock), rst (async active-high reset),
//   bus (sync_fifo_param_if.slave: write/read requests in, data and status out).
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int         DATA_W    = 16,
  parameter int         DEPTH     = 8,
  parameter int         AFULL_TH  = DEPTH - 1,
  parameter int         AEMPTY_TH = 1,
  parameter fifo_mode_e MODE      = FIFO_STD
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be at least 2");
  end
  if (!((AEMPTY_TH >= 0) && (AEMPTY_TH < AFULL_TH) && (AFULL_TH <= DEPTH))) begin : g_bad_th
    $error("sync_fifo_param: thresholds need 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_wr_ack;
  logic              r_overflow;
  logic              r_underflow;
  logic [DATA_W-1:0] r_dout;
  logic              r_dvalid;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_rd_data;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Full blocks only the write and empty only the read, so a simultaneous
  // request at either boundary still moves the other side.
  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_rd_acc = bus.rd_en && !w_empty;

  sync_fifo_param_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_dout      <= '0;
      r_dvalid    <= 1'b0;
    end else begin
      // Explicit wrap keeps non-power-of-two depths correct.
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
        r_dout   <= w_rd_data;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= bus.wr_en && w_full;
      r_underflow <= bus.rd_en && w_empty;
      r_dvalid    <= w_rd_acc;
    end
  end

  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= CNT_W'(AFULL_TH));
  assign bus.almost_empty = (r_count <= CNT_W'(AEMPTY_TH));
  assign bus.wr_ack       = r_wr_ack;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
  // FWFT exposes the head word directly; STD uses the read register.
  assign bus.data_out     = (MODE == FIFO_FWFT) ? w_rd_data : r_dout;
  assign bus.data_valid   = (MODE == FIFO_FWFT) ? !w_empty : r_dvalid;

endmodule
